// File: rtl/f_pc_fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Word width, reset PC, FSM encoding, F/D bundle and PC increments.
package f_pc_fetch_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [WORD_W-1:0] PC_INC       = 32'd4;
  localparam logic [WORD_W-1:0] LINK_INC     = 32'd8;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc8;
  } if_id_t;

  function automatic logic [WORD_W-1:0] word_align(
    input logic [WORD_W-1:0] a
  );
    return {a[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/f_pc_fetch_pipe.sv
// F/D pipeline register: en loads d_i, en+flush turns it into a bubble.
// Ports: clk, rst_n, en_i, flush_i, d_i (if_id_t), q_o (if_id_t).
module fd_pipe_reg
  import f_pc_fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t fd_q;
  if_id_t fd_d;

  always_comb begin
    fd_d = fd_q;
    if (en_i) begin
      if (flush_i) begin
        // bubble keeps the old payload, only valid drops
        fd_d.valid = 1'b0;
      end else begin
        fd_d = d_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fd_q <= '0;
    else        fd_q <= fd_d;
  end

  assign q_o = fd_q;

endmodule

// File: rtl/f_pc_fetch.sv
// Fetch-stage PC unit with skid buffer, redirect handling and F/D reg.
// Ports: clk/rst_n, stall_i, jump_i/target, imem req/addr/ready/rdata, fd_*.
module f_pc_fetch
  import f_pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          DELAY_SLOT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              jump_i,
  input  logic [WORD_W-1:0] jump_target_i,
  output logic              imem_req_o,
  output logic [WORD_W-1:0] imem_addr_o,
  input  logic              imem_ready_i,
  input  logic [WORD_W-1:0] imem_rdata_i,
  output logic              fd_valid_o,
  output logic [WORD_W-1:0] fd_instr_o,
  output logic [WORD_W-1:0] fd_pc_o,
  output logic [WORD_W-1:0] fd_pc8_o
);

  localparam bit SQUASH = (DELAY_SLOT == 0);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [WORD_W-1:0] pend_target_q, pend_target_d;
  logic              hold_valid_q, hold_valid_d;
  logic [WORD_W-1:0] hold_instr_q, hold_instr_d;
  logic [WORD_W-1:0] hold_pc_q, hold_pc_d;

  logic              jmp;
  logic [WORD_W-1:0] tgt;
  logic [WORD_W-1:0] seq_pc;
  logic              fd_en;
  logic              fd_flush;
  if_id_t            fd_d;
  if_id_t            fd_q;

  assign jmp = jump_i & ~stall_i;
  assign tgt = word_align(jump_target_i);

  // a pending redirect outranks a fresh jump and the +4 stream
  assign seq_pc = pend_valid_q ? pend_target_q :
                  jmp          ? tgt           :
                                 pc_q + PC_INC;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    hold_valid_d  = hold_valid_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    fd_en         = 1'b0;
    fd_flush      = 1'b0;
    fd_d.valid    = 1'b1;
    fd_d.instr    = imem_rdata_i;
    fd_d.pc       = pc_q;
    fd_d.pc8      = pc_q + LINK_INC;
    unique case (1'b1)
      (state_q == FETCH): begin
        if (imem_ready_i) begin
          pc_d         = seq_pc;
          pend_valid_d = 1'b0;
          if (!stall_i) begin
            fd_en    = 1'b1;
            fd_flush = SQUASH && jmp;
          end else begin
            hold_valid_d = 1'b1;
            hold_instr_d = imem_rdata_i;
            hold_pc_d    = pc_q;
            state_d      = HOLD;
          end
        end else if (!stall_i) begin
          fd_en    = 1'b1;
          fd_flush = 1'b1;
          if (jmp) begin
            // delay slot (or doomed fetch) still in flight
            pend_valid_d  = 1'b1;
            pend_target_d = tgt;
            if (SQUASH) state_d = DISCARD;
          end
        end
      end
      (state_q == HOLD): begin
        if (!stall_i) begin
          fd_en        = 1'b1;
          fd_d.valid   = hold_valid_q;
          fd_d.instr   = hold_instr_q;
          fd_d.pc      = hold_pc_q;
          fd_d.pc8     = hold_pc_q + LINK_INC;
          hold_valid_d = 1'b0;
          state_d      = FETCH;
          // pc_q already points past the held word
          if (jmp) begin
            pc_d     = tgt;
            fd_flush = SQUASH;
          end
        end
      end
      (state_q == DISCARD): begin
        if (!stall_i) begin
          fd_en    = 1'b1;
          fd_flush = 1'b1;
        end
        if (jmp) pend_target_d = tgt;
        if (imem_ready_i) begin
          pc_d         = jmp ? tgt : pend_target_q;
          pend_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      hold_valid_q  <= 1'b0;
      hold_instr_q  <= '0;
      hold_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      hold_valid_q  <= hold_valid_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
    end
  end

  fd_pipe_reg u_fd (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (fd_en),
    .flush_i (fd_flush),
    .d_i     (fd_d),
    .q_o     (fd_q)
  );

  assign imem_req_o  = (state_q != HOLD);
  assign imem_addr_o = pc_q;
  assign fd_valid_o  = fd_q.valid;
  assign fd_instr_o  = fd_q.instr;
  assign fd_pc_o     = fd_q.pc;
  assign fd_pc8_o    = fd_q.pc8;

endmodule

// File: tb/tb_f_pc_fetch.sv
// Directed bench for f_pc_fetch: delay-slot, squash and wrap instances.
// Table-driven vectors plus hand-written reset and wrap sequences.
module tb_f_pc_fetch;
  import f_pc_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] tgt = '0;
  logic        ready = 1'b0;

  logic        req1, req0, reqw;
  logic [31:0] addr1, addr0, addrw;
  logic [31:0] rd1, rd0, rdw;
  logic        v1, v0, vw;
  logic [31:0] in1, in0, inw;
  logic [31:0] pc1, pc0, pcw;
  logic [31:0] p81, p80, p8w;

  int n_pass = 0;
  int n_total = 0;
  bit sel0 = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign rd1 = instr_of(addr1);
  assign rd0 = instr_of(addr0);
  assign rdw = instr_of(addrw);

  f_pc_fetch #(.DELAY_SLOT(1)) u_ds1 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .jump_i(jump),
    .jump_target_i(tgt), .imem_req_o(req1), .imem_addr_o(addr1),
    .imem_ready_i(ready), .imem_rdata_i(rd1), .fd_valid_o(v1),
    .fd_instr_o(in1), .fd_pc_o(pc1), .fd_pc8_o(p81)
  );

  f_pc_fetch #(.DELAY_SLOT(0)) u_ds0 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .jump_i(jump),
    .jump_target_i(tgt), .imem_req_o(req0), .imem_addr_o(addr0),
    .imem_ready_i(ready), .imem_rdata_i(rd0), .fd_valid_o(v0),
    .fd_instr_o(in0), .fd_pc_o(pc0), .fd_pc8_o(p80)
  );

  f_pc_fetch #(.RESET_PC(32'hFFFF_FFFC), .DELAY_SLOT(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .jump_i(jump),
    .jump_target_i(tgt), .imem_req_o(reqw), .imem_addr_o(addrw),
    .imem_ready_i(ready), .imem_rdata_i(rdw), .fd_valid_o(vw),
    .fd_instr_o(inw), .fd_pc_o(pcw), .fd_pc8_o(p8w)
  );

  logic        s_req, s_v, s_pend;
  logic [31:0] s_addr, s_in, s_pc, s_p8;
  assign s_req  = sel0 ? req0  : req1;
  assign s_addr = sel0 ? addr0 : addr1;
  assign s_v    = sel0 ? v0    : v1;
  assign s_in   = sel0 ? in0   : in1;
  assign s_pc   = sel0 ? pc0   : pc1;
  assign s_p8   = sel0 ? p80   : p81;
  assign s_pend = sel0 ? u_ds0.pend_valid_q : u_ds1.pend_valid_q;

  typedef struct {
    bit          rst;
    bit          ds0;
    bit          stall;
    bit          jump;
    logic [31:0] tgt;
    bit          ready;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
    bit          e_pend;
  } vec_t;

  vec_t tv[$];

  task automatic add(input bit r, input bit d0, input bit s,
                     input bit j, input logic [31:0] t,
                     input bit rdy, input bit rq,
                     input logic [31:0] a, input bit v,
                     input logic [31:0] p, input bit pe);
    vec_t x;
    x.rst = r; x.ds0 = d0; x.stall = s; x.jump = j; x.tgt = t;
    x.ready = rdy; x.e_req = rq; x.e_addr = a; x.e_valid = v;
    x.e_pc = p; x.e_pend = pe;
    tv.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input bit s, input bit j,
                       input logic [31:0] t, input bit r);
    stall = s; jump = j; tgt = t; ready = r;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("rst valid", {31'b0, v1}, 32'd0);
    chk("rst instr", in1, 32'd0);
    chk("rst pc", pc1, 32'd0);
    chk("rst pc8", p81, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // r ds0 st jp tgt rdy | req addr valid pc pend
    // sequential fetch
    add(1,0,0,0,0,1, 1,32'h3000, 1,32'h3000, 0);
    add(0,0,0,0,0,1, 1,32'h3004, 1,32'h3004, 0);
    add(0,0,0,0,0,1, 1,32'h3008, 1,32'h3008, 0);
    // stall with ready at 0x3004, jump ignored under stall
    add(1,0,0,0,0,1, 1,32'h3000, 1,32'h3000, 0);
    add(0,0,1,0,0,1, 1,32'h3004, 1,32'h3000, 0);
    add(0,0,1,0,0,1, 0,32'h3008, 1,32'h3000, 0);
    add(0,0,1,1,32'h3300,1, 0,32'h3008, 1,32'h3000, 0);
    add(0,0,0,0,0,1, 0,32'h3008, 1,32'h3004, 0);
    add(0,0,0,0,0,1, 1,32'h3008, 1,32'h3008, 0);
    // delay slot, jump with ready, unaligned target masked
    add(1,0,0,0,0,1, 1,32'h3000, 1,32'h3000, 0);
    add(0,0,0,0,0,1, 1,32'h3004, 1,32'h3004, 0);
    add(0,0,0,1,32'h3103,1, 1,32'h3008, 1,32'h3008, 0);
    add(0,0,0,0,0,1, 1,32'h3100, 1,32'h3100, 0);
    add(0,0,0,0,0,1, 1,32'h3104, 1,32'h3104, 0);
    // delay slot, jump while slot outstanding
    add(1,0,0,0,0,1, 1,32'h3000, 1,32'h3000, 0);
    add(0,0,0,0,0,1, 1,32'h3004, 1,32'h3004, 0);
    add(0,0,0,1,32'h3100,0, 1,32'h3008, 0,32'h0, 1);
    add(0,0,0,0,0,0, 1,32'h3008, 0,32'h0, 1);
    add(0,0,0,0,0,1, 1,32'h3008, 1,32'h3008, 0);
    add(0,0,0,0,0,1, 1,32'h3100, 1,32'h3100, 0);
    add(0,0,0,0,0,1, 1,32'h3104, 1,32'h3104, 0);
    // second jump overwrites the pending target
    add(1,0,0,0,0,1, 1,32'h3000, 1,32'h3000, 0);
    add(0,0,0,0,0,1, 1,32'h3004, 1,32'h3004, 0);
    add(0,0,0,1,32'h3100,0, 1,32'h3008, 0,32'h0, 1);
    add(0,0,0,1,32'h3180,0, 1,32'h3008, 0,32'h0, 1);
    add(0,0,0,0,0,1, 1,32'h3008, 1,32'h3008, 0);
    add(0,0,0,0,0,1, 1,32'h3180, 1,32'h3180, 0);
    // no delay slot, jump while fetch outstanding -> discard
    add(1,1,0,0,0,1, 1,32'h3000, 1,32'h3000, 0);
    add(0,1,0,0,0,1, 1,32'h3004, 1,32'h3004, 0);
    add(0,1,0,1,32'h3200,0, 1,32'h3008, 0,32'h0, 1);
    add(0,1,0,0,0,1, 1,32'h3008, 0,32'h0, 0);
    add(0,1,0,0,0,1, 1,32'h3200, 1,32'h3200, 0);
    // no delay slot, jump with ready -> squash, redirect now
    add(1,1,0,0,0,1, 1,32'h3000, 1,32'h3000, 0);
    add(0,1,0,0,0,1, 1,32'h3004, 1,32'h3004, 0);
    add(0,1,0,1,32'h3200,1, 1,32'h3008, 0,32'h0, 0);
    add(0,1,0,0,0,1, 1,32'h3200, 1,32'h3200, 0);

    foreach (tv[i]) begin
      if (tv[i].rst) do_reset();
      sel0 = tv[i].ds0;
      drive(tv[i].stall, tv[i].jump, tv[i].tgt, tv[i].ready);
      #2;
      chk($sformatf("v%0d req", i), {31'b0, s_req},
          {31'b0, tv[i].e_req});
      chk($sformatf("v%0d addr", i), s_addr, tv[i].e_addr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d valid", i), {31'b0, s_v},
          {31'b0, tv[i].e_valid});
      if (tv[i].e_valid) begin
        chk($sformatf("v%0d pc", i), s_pc, tv[i].e_pc);
        chk($sformatf("v%0d pc8", i), s_p8, tv[i].e_pc + 32'd8);
        chk($sformatf("v%0d instr", i), s_in,
            instr_of(tv[i].e_pc));
      end
      chk($sformatf("v%0d pend", i), {31'b0, s_pend},
          {31'b0, tv[i].e_pend});
    end

    // reset pulsed while in HOLD
    sel0 = 1'b0;
    do_reset();
    drive(0, 0, 0, 1);
    @(posedge clk); #1;
    drive(1, 0, 0, 1);
    @(posedge clk); #1;
    chk("hold req", {31'b0, req1}, 32'd0);
    chk("hold fd pc", pc1, 32'h3000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst valid", {31'b0, v1}, 32'd0);
    chk("arst pc", pc1, 32'd0);
    chk("arst instr", in1, 32'd0);
    chk("arst req", {31'b0, req1}, 32'd1);
    chk("arst addr", addr1, 32'h3000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 1);
    #2;
    chk("post rst addr", addr1, 32'h3000);
    chk("post rst req", {31'b0, req1}, 32'd1);
    @(posedge clk); #1;
    chk("post rst valid", {31'b0, v1}, 32'd1);
    chk("post rst pc", pc1, 32'h3000);

    // PC adders wrap modulo 2^32
    do_reset();
    drive(0, 0, 0, 1);
    #2;
    chk("wrap addr0", addrw, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap fd pc", pcw, 32'hFFFF_FFFC);
    chk("wrap fd pc8", p8w, 32'h0000_0004);
    chk("wrap valid", {31'b0, vw}, 32'd1);
    chk("wrap instr", inw, instr_of(32'hFFFF_FFFC));
    chk("wrap addr1", addrw, 32'h0000_0000);
    @(posedge clk); #1;
    chk("wrap fd pc b", pcw, 32'h0000_0000);
    chk("wrap fd pc8 b", p8w, 32'h0000_0008);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
